// File: rtl/div_iter.sv
// ---------------------------------------------------------------------------
// div_iter : multi-cycle iterative restoring divider (DIV / DIVU).
//
// One quotient bit per clock, MSB first, using a (WIDTH+1)-bit trial
// subtract. Signed operations divide magnitudes and fix the signs up at
// the end: the quotient is negated when the operand signs differ, and the
// remainder always takes the sign of the dividend.
//
// Ports
//   clk       rising-edge clock
//   reset     asynchronous, active-high reset
//   Start     request, sampled only while Busy=0
//   A, B      dividend, divisor
//   Signed    1: two's-complement DIV, 0: unsigned DIVU
//   Busy      operation in progress (Start ignored)
//   Done      one-cycle pulse, Q/R/flags valid from this cycle
//   Q, R      quotient (LO), remainder (HI)
//   DivZero   divisor was zero on the accepted request
//   Overflow  signed most-negative / -1
//
// Build option
//   DIV_EARLY_OUT_EN : when |B| > |A| the iterations are skipped and the
//   result (Q=0, R=A) is produced two edges after acceptance. Results are
//   identical with or without it; only latency changes.
// ---------------------------------------------------------------------------
module div_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Signed,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             DivZero,
    output logic             Overflow
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] dvd_reg;    // dividend shifting out, quotient shifting in
    logic [WIDTH-1:0] rem_reg;    // partial remainder
    logic [WIDTH-1:0] mag_b_reg;  // divisor magnitude
    logic             neg_q_reg;
    logic             neg_r_reg;
    logic             skip_reg;   // short path: no iterations needed
    logic [CW-1:0]    cnt_reg;

    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic             early_out;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH+1:0] trial;
    logic             qbit;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] q_final;
    logic [WIDTH-1:0] r_final;

    // Magnitudes; the most-negative value maps onto itself, which is its
    // correct unsigned magnitude.
    assign mag_a = (Signed && A[WIDTH-1]) ? -A : A;
    assign mag_b = (Signed && B[WIDTH-1]) ? -B : B;

`ifdef DIV_EARLY_OUT_EN
    assign early_out = (mag_b > mag_a);
`else
    assign early_out = 1'b0;
`endif

    // Trial subtract; the extra top bit of trial is the borrow.
    assign rem_shift = {rem_reg, dvd_reg[WIDTH-1]};
    assign trial     = {1'b0, rem_shift} - {2'b00, mag_b_reg};
    assign qbit      = ~trial[WIDTH+1];
    // Either result is below the divisor magnitude, so WIDTH bits suffice.
    assign rem_next  = qbit ? trial[WIDTH-1:0] : rem_shift[WIDTH-1:0];

    assign q_final = neg_q_reg ? -dvd_reg : dvd_reg;
    assign r_final = neg_r_reg ? -rem_reg : rem_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= S_IDLE;
            dvd_reg   <= '0;
            rem_reg   <= '0;
            mag_b_reg <= '0;
            neg_q_reg <= 1'b0;
            neg_r_reg <= 1'b0;
            skip_reg  <= 1'b0;
            cnt_reg   <= '0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
            Q         <= '0;
            R         <= '0;
            DivZero   <= 1'b0;
            Overflow  <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (Start) begin
                        Busy      <= 1'b1;
                        DivZero   <= (B == '0);
                        Overflow  <= Signed && (A == MOST_NEG) && (B == '1);
                        mag_b_reg <= mag_b;
                        neg_q_reg <= Signed & (A[WIDTH-1] ^ B[WIDTH-1]);
                        neg_r_reg <= Signed & A[WIDTH-1];
                        cnt_reg   <= '0;
                        state_reg <= S_RUN;
                        if ((B == '0) || early_out) begin
                            // q=0, rem=|A|: sign fix-up then restores R=A.
                            skip_reg <= 1'b1;
                            dvd_reg  <= '0;
                            rem_reg  <= mag_a;
                        end else begin
                            skip_reg <= 1'b0;
                            dvd_reg  <= mag_a;
                            rem_reg  <= '0;
                        end
                    end
                end
                S_RUN: begin
                    // Short paths spend this single cycle here without
                    // iterating, so their Done lands two edges after Start.
                    if (skip_reg) begin
                        state_reg <= S_FIX;
                    end else begin
                        dvd_reg <= {dvd_reg[WIDTH-2:0], qbit};
                        rem_reg <= rem_next;
                        cnt_reg <= cnt_reg + 1'b1;
                        if (cnt_reg == CW'(WIDTH - 1))
                            state_reg <= S_FIX;
                    end
                end
                S_FIX: begin
                    // Overflow needs no special case: |q| = 2^(W-1) with
                    // both signs negative already yields MOST_NEG, R=0.
                    Q         <= DivZero ? '1 : q_final;
                    R         <= r_final;
                    Busy      <= 1'b0;
                    Done      <= 1'b1;
                    state_reg <= S_IDLE;
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_iter.sv
// ---------------------------------------------------------------------------
// tb_div_iter : scoreboard bench for div_iter. The driver pushes the
// hand-computed result of every accepted request; a monitor pops and
// compares whenever Done is seen.
// ---------------------------------------------------------------------------
module tb_div_iter;

    logic        clk = 1'b0;
    logic        reset;
    logic        Start;
    logic [31:0] A, B;
    logic        Signed;
    logic        Busy, Done, DivZero, Overflow;
    logic [31:0] Q, R;

    div_iter #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .Start(Start), .A(A), .B(B),
        .Signed(Signed), .Busy(Busy), .Done(Done), .Q(Q), .R(R),
        .DivZero(DivZero), .Overflow(Overflow)
    );

    always #5 clk = ~clk;

`ifdef DIV_EARLY_OUT_EN
    localparam int EO_LAT = 2;
`else
    localparam int EO_LAT = 33;
`endif

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        logic        ov;
        int          lat;
        int          acc;
        int          id;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   op_id = 0;
    int   done_seen = 0;
    bit   busy_gap = 0;
    bit   prev_done = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    // Present a request at a negedge and hold it until a cycle with Busy=0,
    // so it is accepted at the following posedge.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input logic [31:0] q, input logic [31:0] r,
                         input logic dz, input logic ov, input int lat);
        bit   ok;
        exp_t e;
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            A = a; B = b; Signed = s; Start = 1'b1;
            if (!Busy) begin ok = 1; break; end
        end
        if (!ok) begin
            Start = 1'b0;
            chk($sformatf("op%0d accept_timeout", op_id), 32'd1, 32'd0);
            return;
        end
        @(posedge clk);
        #1;
        e.q = q; e.r = r; e.dz = dz; e.ov = ov; e.lat = lat; e.acc = cyc; e.id = op_id;
        sb.push_back(e);
        op_id++;
        Start  = 1'b0;
        A      = $urandom;
        B      = $urandom;
        Signed = 1'($urandom);
    endtask

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (prev_done) chk("done_one_cycle", {31'd0, Done}, 32'd0);
            prev_done = Done;
            if (Done) begin
                done_seen++;
                if (sb.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    $display("op%0d done Q=%h R=%h DivZero=%0b Overflow=%0b lat=%0d",
                             e.id, Q, R, DivZero, Overflow, cyc - e.acc);
                    chk($sformatf("op%0d Q", e.id), Q, e.q);
                    chk($sformatf("op%0d R", e.id), R, e.r);
                    chk($sformatf("op%0d DivZero", e.id), {31'd0, DivZero}, {31'd0, e.dz});
                    chk($sformatf("op%0d Overflow", e.id), {31'd0, Overflow}, {31'd0, e.ov});
                    chk($sformatf("op%0d latency", e.id), 32'(cyc - e.acc), 32'(e.lat));
                    chk($sformatf("op%0d busy_gap", e.id), {31'd0, busy_gap}, 32'd0);
                    busy_gap = 0;
                end
            end else if (sb.size() > 0 && !Busy) begin
                busy_gap = 1;
            end
        end
    end

    // Driver
    initial begin
        int snap;
        reset = 1'b1; Start = 1'b0; A = '0; B = '0; Signed = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset Busy", {31'd0, Busy}, 32'd0);
        chk("reset Done", {31'd0, Done}, 32'd0);
        chk("reset Q", Q, 32'd0);
        chk("reset R", R, 32'd0);
        chk("reset DivZero", {31'd0, DivZero}, 32'd0);
        chk("reset Overflow", {31'd0, Overflow}, 32'd0);
        reset = 1'b0;

        // Unsigned and signed sign fix-up
        do_op(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 1'b0, 33);
        do_op(-32'sd7, 32'd2, 1'b1, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 1'b0, 33);
        do_op(32'd7, -32'sd2, 1'b1, 32'hFFFFFFFD, 32'd1, 1'b0, 1'b0, 33);
        do_op(-32'sd7, -32'sd2, 1'b1, 32'd3, 32'hFFFFFFFF, 1'b0, 1'b0, 33);
        do_op(-32'sd100, 32'd7, 1'b1, 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0, 1'b0, 33);

        // Divide by zero, signed overflow, unsigned counterpart
        do_op(32'h1234, 32'd0, 1'b0, 32'hFFFFFFFF, 32'h1234, 1'b1, 1'b0, 2);
        do_op(-32'sd5, 32'd0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFB, 1'b1, 1'b0, 2);
        do_op(32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 32'd0, 1'b0, 1'b1, 33);
        do_op(32'h80000000, 32'hFFFFFFFF, 1'b0, 32'd0, 32'h80000000, 1'b0, 1'b0, EO_LAT);

        // Start pulsed mid-RUN with new operands is ignored
        do_op(32'd1000, 32'd10, 1'b0, 32'd100, 32'd0, 1'b0, 1'b0, 33);
        repeat (5) @(negedge clk);
        A = 32'hFFFF; B = 32'd1; Signed = 1'b0; Start = 1'b1;
        @(negedge clk);
        Start = 1'b0;

        // Back-to-back: second request held high until the Done cycle
        do_op(32'h12345678, 32'h100, 1'b0, 32'h00123456, 32'h78, 1'b0, 1'b0, 33);
        do_op(32'd50, -32'sd7, 1'b1, 32'hFFFFFFF9, 32'd1, 1'b0, 1'b0, 33);

        // Reset at iteration 10 aborts the operation
        do_op(32'hFFFFFFFF, 32'd3, 1'b0, 32'h55555555, 32'd0, 1'b0, 1'b0, 33);
        repeat (10) @(posedge clk);
        #2;
        reset = 1'b1;
        sb.delete();
        busy_gap = 0;
        #1;
        chk("async_reset Busy", {31'd0, Busy}, 32'd0);
        chk("async_reset Done", {31'd0, Done}, 32'd0);
        chk("async_reset Q", Q, 32'd0);
        chk("async_reset R", R, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        snap = done_seen;
        repeat (40) @(negedge clk);
        chk("no_done_after_reset", 32'(done_seen - snap), 32'd0);
        do_op(32'hFFFFFFFF, 32'h10, 1'b0, 32'h0FFFFFFF, 32'hF, 1'b0, 1'b0, 33);

        // Divisor larger than dividend
        do_op(32'd5, 32'd9, 1'b0, 32'd0, 32'd5, 1'b0, 1'b0, EO_LAT);

        // Drain the scoreboard within a bounded time
        for (int i = 0; i < 100 && sb.size() > 0; i++) @(negedge clk);
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk($sformatf("op%0d done_timeout", e.id), 32'd1, 32'd0);
        end
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
